// File: rtl/running_extreme.sv
// Per-frame running maximum/minimum tracker with the position of the extreme.
// Mode and signedness are captured on the first sample of each frame.
module running_extreme #(
    parameter int WIDTH     = 3,
    parameter int FRAME_LEN = 8,
    parameter int IDXW      = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode_min,
    input  logic             sgn,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_idx
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [IDXW:0] LAST = (IDXW+1)'(FRAME_LEN - 1);
    localparam logic [IDXW:0] ONE  = (IDXW+1)'(1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] ext;
    logic [IDXW-1:0]  ext_idx;
    logic [IDXW:0]    cnt;
    logic             lat_min;
    logic             lat_sgn;

    logic [WIDTH-1:0] key_in;
    logic [WIDTH-1:0] key_ext;
    logic             better;
    logic             start;
    logic             step;
    logic             last;

    // Flipping the sign bit turns a two's-complement order into an unsigned one.
    assign key_in  = {in_data[WIDTH-1] ^ lat_sgn, in_data[WIDTH-2:0]};
    assign key_ext = {ext[WIDTH-1] ^ lat_sgn, ext[WIDTH-2:0]};
    assign better  = lat_min ? (key_in < key_ext) : (key_in > key_ext);

    assign start = !abort && in_valid && (state != ACC);
    assign step  = !abort && in_valid && (state == ACC);
    assign last  = step && (cnt == LAST);

    assign busy      = (state == ACC);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: state_nx = in_valid ? ACC : IDLE;
                ACC:        if (last) state_nx = DONE;
                default:    state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext      <= '0;
            ext_idx  <= '0;
            cnt      <= '0;
            lat_min  <= 1'b0;
            lat_sgn  <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            ext     <= in_data;
            ext_idx <= '0;
            cnt     <= ONE;
            lat_min <= mode_min;
            lat_sgn <= sgn;
        end else if (step) begin
            cnt <= cnt + ONE;
            if (better) begin
                ext     <= in_data;
                ext_idx <= cnt[IDXW-1:0];
            end
            // Publish the result including the frame's final sample.
            if (last) begin
                cnt      <= '0;
                out_data <= better ? in_data : ext;
                out_idx  <= better ? cnt[IDXW-1:0] : ext_idx;
            end
        end
    end

endmodule

// File: tb/tb_running_extreme.sv
// Table-driven and scoreboard bench for running_extreme (WIDTH=3, FRAME_LEN=8).
module tb_running_extreme;

    localparam int W  = 3;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          mode_min;
    logic          sgn;
    logic          abort;
    logic          busy;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;

    running_extreme #(.WIDTH(W), .FRAME_LEN(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .mode_min(mode_min), .sgn(sgn), .abort(abort), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] s;
        logic        mm;
        logic        sg;
        logic [2:0]  ed;
        logic [2:0]  ei;
    } vec_t;

    typedef struct packed {
        logic [2:0]  d;
        logic [2:0]  i;
        logic [31:0] cyc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 0;
    exp_t        sbq[$];
    vec_t        vecs[12];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [23:0] pk(int a0, int a1, int a2, int a3,
                                       int a4, int a5, int a6, int a7);
        return {a7[2:0], a6[2:0], a5[2:0], a4[2:0],
                a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
                e = sbq.pop_front();
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_idx", 32'(out_idx), 32'(e.i));
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic run_frame(vec_t v, bit gaps, bit toggle);
        for (int i = 0; i < N; i++) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    if (toggle) begin
                        mode_min = ~mode_min;
                        sgn      = ~sgn;
                    end
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = v.s[3*i +: 3];
            mode_min = (i == 0 || !toggle) ? v.mm : ~v.mm;
            sgn      = (i == 0 || !toggle) ? v.sg : ~v.sg;
            if (i == N - 1) sbq.push_back('{v.ed, v.ei, cyc + 1});
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        mode_min = 1'b0;
        sgn      = 1'b0;
        abort    = 1'b0;
        #2;
        check("reset_busy", 32'(busy), 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_data", 32'(out_data), 0);
        check("reset_out_idx", 32'(out_idx), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        vecs[0]  = '{pk(2,5,1,7,7,0,3,6), 1'b0, 1'b0, 3'd7, 3'd3};
        vecs[1]  = '{pk(2,5,1,7,7,0,3,6), 1'b1, 1'b1, 3'd5, 3'd1};
        vecs[2]  = '{pk(2,5,1,7,7,0,3,6), 1'b1, 1'b0, 3'd0, 3'd5};
        vecs[3]  = '{pk(2,5,1,7,7,0,3,6), 1'b0, 1'b1, 3'd3, 3'd6};
        vecs[4]  = '{pk(4,4,4,4,4,4,4,4), 1'b0, 1'b0, 3'd4, 3'd0};
        vecs[5]  = '{pk(4,4,4,4,4,4,4,4), 1'b1, 1'b1, 3'd4, 3'd0};
        vecs[6]  = '{pk(0,1,2,3,4,5,6,7), 1'b0, 1'b1, 3'd3, 3'd3};
        vecs[7]  = '{pk(0,1,2,3,4,5,6,7), 1'b1, 1'b1, 3'd4, 3'd4};
        vecs[8]  = '{pk(7,6,5,4,3,2,1,0), 1'b0, 1'b0, 3'd7, 3'd0};
        vecs[9]  = '{pk(7,6,5,4,3,2,1,0), 1'b1, 1'b0, 3'd0, 3'd7};
        vecs[10] = '{pk(1,2,3,4,5,6,7,8), 1'b0, 1'b0, 3'd7, 3'd6};
        vecs[11] = '{pk(3,3,3,3,3,3,3,4), 1'b0, 1'b1, 3'd3, 3'd0};

        for (int k = 0; k < 12; k++) begin
            run_frame(vecs[k], 1'b0, 1'b0);
            idle();
            idle();
        end

        // back-to-back frames, in_valid held high for 16 cycles
        run_frame(vecs[0], 1'b0, 1'b0);
        run_frame(vecs[9], 1'b0, 1'b0);
        idle();

        // last result (7 @ 3) must hold during the next accumulation
        run_frame(vecs[0], 1'b0, 1'b0);
        idle();
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 3'd6;
            mode_min = 1'b0;
            sgn      = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_acc", 32'(busy), 1);
        check("hold_out_data", 32'(out_data), 7);
        check("hold_out_idx", 32'(out_idx), 3);
        in_valid = 1'b1;
        in_data  = 3'd7;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_abort", 32'(busy), 0);
        run_frame(vecs[10], 1'b0, 1'b0);

        // abort while DONE keeps the pulse already asserted
        run_frame(vecs[3], 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b1;
        idle();

        // asynchronous reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 3'd7;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_data", 32'(out_data), 0);
        check("async_rst_out_idx", 32'(out_idx), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        run_frame(vecs[1], 1'b0, 1'b0);
        idle();

        // gaps between samples with mode/sign toggling mid-frame
        run_frame(vecs[1], 1'b1, 1'b1);
        run_frame(vecs[0], 1'b1, 1'b1);
        run_frame(vecs[9], 1'b1, 1'b1);
        idle();

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", 32'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
